// File: rtl/prio_event_encoder.sv
// Registered priority encoder with sticky request capture.
// Presents one pending index at a time under a valid/ack handshake.
module prio_event_encoder #(
  parameter int N = 15,
  parameter int OUT_W = 8,
  parameter logic [OUT_W-1:0] NONE_CODE = OUT_W'(8'hF0),
  parameter bit RR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             edge_mode,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic             valid,
  output logic [OUT_W-1:0] code_out,
  output logic [N-1:0]     pending,
  output logic             overflow
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [N-1:0]     req_q;
  logic [N-1:0]     hit;
  logic [N-1:0]     clr;
  logic [N-1:0]     cand;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    base;
  logic [IW-1:0]    sel;
  logic [OUT_W-1:0] code_d;
  logic             accept;

  assign valid  = (state_q == PRESENT);
  assign accept = valid & ack;

  assign hit  = en ? (edge_mode ? (req & ~req_q) : req) : '0;
  assign cand = pending & ~clr;

  // An accepted index acts as the new round-robin anchor at once.
  assign base = accept ? idx_q : last_q;

  // One-hot clear of the index being accepted this cycle.
  always_comb begin
    clr = '0;
    if (accept) clr[idx_q] = 1'b1;
  end

  // Pick the winning candidate; later loop hits override earlier ones.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    sel = '0;
    j   = 0;
    jj  = '0;
    if (RR) begin
      for (int k = N; k >= 1; k--) begin
        j = int'(base) - k;
        if (j < 0) j = j + N;
        jj = IW'(j);
        if (cand[jj]) sel = jj;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        jj = IW'(i);
        if (cand[jj]) sel = jj;
      end
    end
  end

  // Handshake FSM: next state, next index and next code.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_out;
    unique case (state_q)
      IDLE: begin
        if (|pending) begin
          state_d = PRESENT;
          idx_d   = sel;
          code_d  = OUT_W'(sel);
        end
      end
      PRESENT: begin
        if (ack) begin
          if (|cand) begin
            idx_d  = sel;
            code_d = OUT_W'(sel);
          end else begin
            state_d = IDLE;
            code_d  = NONE_CODE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = NONE_CODE;
      end
    endcase
  end

  // FSM state and presented code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      code_out <= NONE_CODE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      code_out <= code_d;
    end
  end

  // Request history, sticky pending set, round-robin anchor, overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      pending  <= '0;
      last_q   <= '0;
      overflow <= 1'b0;
    end else begin
      req_q    <= req;
      pending  <= cand | hit;
      overflow <= overflow | (|(hit & cand));
      if (accept) last_q <= idx_q;
    end
  end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Bench for prio_event_encoder: fixed-priority and round-robin
// instances against a queue-ordered reference model.
module tb_prio_event_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        edge_mode = 1'b0;
  logic [14:0] req = '0;
  logic        ack0 = 1'b0;
  logic        ack1 = 1'b0;

  logic        valid0;
  logic        valid1;
  logic [7:0]  code0;
  logic [7:0]  code1;
  logic [14:0] pend0;
  logic [14:0] pend1;
  logic        ovf0;
  logic        ovf1;

  int checks = 0;
  int errors = 0;

  bit [14:0] m_pend[2];
  bit        m_valid[2];
  bit        m_ovf[2];
  int        m_idx[2];
  int        m_last[2];
  bit [14:0] m_reqq;

  always #5 clk = ~clk;

  prio_event_encoder #(
    .N(15), .OUT_W(8), .NONE_CODE(8'hF0), .RR(1'b0)
  ) u0 (
    .clk(clk), .rst(rst), .en(en), .edge_mode(edge_mode),
    .req(req), .ack(ack0), .valid(valid0), .code_out(code0),
    .pending(pend0), .overflow(ovf0)
  );

  prio_event_encoder #(
    .N(15), .OUT_W(8), .NONE_CODE(8'hF0), .RR(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .edge_mode(edge_mode),
    .req(req), .ack(ack1), .valid(valid1), .code_out(code1),
    .pending(pend1), .overflow(ovf1)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Winner = first pending index in the arbitration order list.
  function automatic int pick(bit [14:0] v, int rr, int base);
    int order[$];
    order = {};
    if (rr == 0) begin
      for (int i = 14; i >= 0; i--) order.push_back(i);
    end else begin
      for (int i = base - 1; i >= 0; i--) order.push_back(i);
      for (int i = 14; i >= base; i--) order.push_back(i);
    end
    foreach (order[k]) if (v[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_step();
    bit [14:0] hit;
    bit [14:0] clr;
    bit [14:0] cand;
    bit        acc;
    int        base;
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        m_pend[r]  = '0;
        m_valid[r] = 1'b0;
        m_ovf[r]   = 1'b0;
        m_idx[r]   = 0;
        m_last[r]  = 0;
      end
      m_reqq = '0;
      return;
    end
    hit = en ? (edge_mode ? (req & ~m_reqq) : req) : '0;
    for (int r = 0; r < 2; r++) begin
      acc  = m_valid[r] && ((r == 0) ? ack0 : ack1);
      clr  = acc ? (15'(1) << m_idx[r]) : '0;
      cand = m_pend[r] & ~clr;
      if ((hit & cand) != 0) m_ovf[r] = 1'b1;
      base = acc ? m_idx[r] : m_last[r];
      if (acc) m_last[r] = m_idx[r];
      if (!m_valid[r]) begin
        if (m_pend[r] != 0) begin
          m_valid[r] = 1'b1;
          m_idx[r]   = pick(m_pend[r], r, base);
        end
      end else if (acc) begin
        if (cand != 0) m_idx[r] = pick(cand, r, base);
        else m_valid[r] = 1'b0;
      end
      m_pend[r] = cand | hit;
    end
    m_reqq = req;
  endtask

  task automatic compare_all();
    logic [31:0] e0;
    logic [31:0] e1;
    e0 = m_valid[0] ? 32'(m_idx[0]) : 32'hF0;
    e1 = m_valid[1] ? 32'(m_idx[1]) : 32'hF0;
    check("valid0", 32'(valid0), 32'(m_valid[0]));
    check("code0", 32'(code0), e0);
    check("pend0", 32'(pend0), 32'(m_pend[0]));
    check("ovf0", 32'(ovf0), 32'(m_ovf[0]));
    check("valid1", 32'(valid1), 32'(m_valid[1]));
    check("code1", 32'(code1), e1);
    check("pend1", 32'(pend1), 32'(m_pend[1]));
    check("ovf1", 32'(ovf1), 32'(m_ovf[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic acks(logic a);
    ack0 = a;
    ack1 = a;
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_code", 32'(code0), 32'hF0);
    check("rst_pend", 32'(pend0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;

    // Fixed priority, level mode, ack every cycle
    en = 1'b1;
    req = 15'h0412;
    tick();
    check("lat_novalid", 32'(valid0), 32'd0);
    req = '0;
    tick();
    check("lat_valid", 32'(valid0), 32'd1);
    check("fp_code_a", 32'(code0), 32'h0A);
    acks(1'b1);
    tick();
    check("fp_code_4", 32'(code0), 32'h04);
    tick();
    check("fp_code_1", 32'(code0), 32'h01);
    tick();
    check("fp_end_valid", 32'(valid0), 32'd0);
    check("fp_end_code", 32'(code0), 32'hF0);
    acks(1'b0);

    // Hold stability while a higher request arrives
    req = 15'h0412;
    tick();
    req = '0;
    tick();
    acks(1'b1);
    tick();
    acks(1'b0);
    check("hold_pre", 32'(code0), 32'h04);
    req = 15'h4000;
    tick();
    check("hold_a", 32'(code0), 32'h04);
    req = '0;
    tick();
    check("hold_b", 32'(code0), 32'h04);
    acks(1'b1);
    tick();
    check("hold_next", 32'(code0), 32'h0E);
    repeat (6) tick();
    check("hold_drain0", 32'(valid0), 32'd0);
    check("hold_drain1", 32'(valid1), 32'd0);
    acks(1'b0);

    // Round-robin in edge mode
    rst = 1'b1;
    tick();
    rst = 1'b0;
    edge_mode = 1'b1;
    req = 15'h0888;
    tick();
    tick();
    check("rr_first", 32'(code1), 32'h0B);
    acks(1'b1);
    tick();
    check("rr_second", 32'(code1), 32'h07);
    tick();
    check("rr_third", 32'(code1), 32'h03);
    tick();
    check("rr_idle", 32'(valid1), 32'd0);
    acks(1'b0);
    req = '0;
    tick();
    req = 15'h0888;
    tick();
    tick();
    check("rr2_first", 32'(code1), 32'h0B);
    acks(1'b1);
    tick();
    check("rr2_second", 32'(code1), 32'h07);
    tick();
    check("rr2_third", 32'(code1), 32'h03);
    tick();
    acks(1'b0);
    req = '0;

    // Same-cycle hit/clear collision, then overflow
    rst = 1'b1;
    tick();
    rst = 1'b0;
    edge_mode = 1'b0;
    req = 15'h0220;
    tick();
    req = '0;
    tick();
    check("col_code", 32'(code0), 32'h09);
    req = 15'h0200;
    acks(1'b1);
    tick();
    check("col_pend9", 32'(pend0[9]), 32'd1);
    check("col_ovf", 32'(ovf0), 32'd0);
    check("col_next", 32'(code0), 32'h05);
    req = 15'h0200;
    acks(1'b0);
    tick();
    check("ovf_set", 32'(ovf0), 32'd1);
    req = '0;
    tick();
    check("ovf_sticky", 32'(ovf0), 32'd1);
    acks(1'b1);
    repeat (4) tick();
    check("ovf_drain_v", 32'(valid0), 32'd0);
    check("ovf_drain_o", 32'(ovf0), 32'd1);
    acks(1'b0);

    // Enable low: no capture, existing bits still drain
    req = 15'h0003;
    tick();
    req = '0;
    tick();
    en = 1'b0;
    repeat (2) begin
      req = 15'($urandom);
      tick();
    end
    check("en_hold", 32'(pend0), 32'h0003);
    acks(1'b1);
    repeat (3) begin
      req = 15'($urandom);
      tick();
    end
    check("en_drain_p", 32'(pend0), 32'd0);
    check("en_drain_v", 32'(valid0), 32'd0);
    acks(1'b0);

    // Reset mid-handshake, line high at release counts as edge
    en = 1'b1;
    req = 15'h0100;
    tick();
    req = '0;
    tick();
    check("mid_valid", 32'(valid0), 32'd1);
    acks(1'b1);
    rst = 1'b1;
    edge_mode = 1'b1;
    req = 15'h0100;
    tick();
    check("mid_rst_v", 32'(valid0), 32'd0);
    check("mid_rst_c", 32'(code0), 32'hF0);
    check("mid_rst_p", 32'(pend0), 32'd0);
    check("mid_rst_o", 32'(ovf0), 32'd0);
    rst = 1'b0;
    acks(1'b0);
    tick();
    check("rel_edge", 32'(pend0), 32'h0100);
    req = '0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 7) != 0);
      edge_mode = 1'($urandom_range(0, 1));
      req = 15'($urandom) & 15'($urandom) & 15'($urandom);
      ack0 = ($urandom_range(0, 3) != 0);
      ack1 = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
